// File: rtl/timebase_pkg.sv
// timebase_pkg: shared state encoding and default sizing for the board timebase divider.
// Types/constants only; no latency or backpressure of its own.
package timebase_pkg;

  localparam int          DEF_CNT_W      = 30;
  localparam int unsigned DEF_PERIOD_CYC = 50_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } tb_state_e;

endpackage

// File: rtl/tb_divcnt.sv
// tb_divcnt: clear/enable up-counter wrapping at period-1; tc is combinational from the count.
// Count updates one edge after en/clr; no backpressure.
module tb_divcnt
  import timebase_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // period is never zero, so period-1 cannot underflow
  assign tc = (cnt == period - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/timebase_ctrl.sv
// timebase_ctrl: start/stop/pause run control over tb_divcnt; tick/wave/done registered, first tick P edges after start.
// No backpressure; TIMEBASE_SHADOW_LOAD_EN adds a shadow period applied at the next terminal count.
module timebase_ctrl
  import timebase_pkg::*;
#(
  parameter int          CNT_W      = DEF_CNT_W,
  parameter int unsigned DEF_PERIOD = DEF_PERIOD_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             load,
  input  logic [CNT_W-1:0] period_in,
  output logic             tick,
  output logic             wave,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  tb_state_e        state;
  logic [CNT_W-1:0] period_reg;
  logic             mode;
  logic             tc;
  logic             tc_fire;
  logic             cnt_en;
  logic             cnt_clr;
  logic             load_ok;

`ifdef TIMEBASE_SHADOW_LOAD_EN
  logic [CNT_W-1:0] shadow;
  logic             pending;
`endif

  assign tc_fire = (state == RUN) && tc;
  // a terminal count still wraps the counter even when stop arrives on the same edge
  assign cnt_en  = (state == RUN) && (tc || !stop);
  assign cnt_clr = (state == IDLE) || ((state == PAUSE) && stop);
  assign load_ok = load && (period_in != '0);
  assign busy    = (state == RUN) || (state == PAUSE);

  tb_divcnt #(.CNT_W(CNT_W)) u_divcnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .period (period_reg),
    .cnt    (count),
    .tc     (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      period_reg <= CNT_W'(DEF_PERIOD);
      mode       <= 1'b0;
      tick       <= 1'b0;
      wave       <= 1'b0;
      done       <= 1'b0;
`ifdef TIMEBASE_SHADOW_LOAD_EN
      shadow     <= '0;
      pending    <= 1'b0;
`endif
    end else begin
      tick <= tc_fire;
      done <= tc_fire && mode;
      if (tc_fire) wave <= ~wave;

      case (state)
        IDLE: begin
          if (load_ok) period_reg <= period_in;
          if (start && !stop) begin
            state <= RUN;
            mode  <= oneshot;
          end
        end
        RUN: begin
          if (tc_fire && mode) state <= IDLE;
          else if (stop)       state <= PAUSE;
        end
        PAUSE: begin
          if (stop) begin
            state <= IDLE;
            wave  <= 1'b0;
          end else if (start) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef TIMEBASE_SHADOW_LOAD_EN
      // leaving via stop drops any staged period; IDLE loads go straight to period_reg
      if ((state == IDLE) || ((state == PAUSE) && stop)) begin
        pending <= 1'b0;
      end else begin
        if (tc_fire && pending) begin
          period_reg <= shadow;
          pending    <= 1'b0;
        end
        if (load_ok) begin
          shadow  <= period_in;
          pending <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_timebase_ctrl.sv
// Bench for timebase_ctrl: expected tick/done cycles are queued at stimulus time and matched by a negedge monitor.
module tb_timebase_ctrl;

  localparam int CNT_W = 30;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             oneshot;
  logic             load;
  logic [CNT_W-1:0] period_in;
  logic             tick;
  logic             wave;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;
  int exp_tick_q[$];
  int exp_done_q[$];
  int e_tick;
  int e_done;

  timebase_ctrl #(.CNT_W(CNT_W), .DEF_PERIOD(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .load      (load),
    .period_in (period_in),
    .tick      (tick),
    .wave      (wave),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor: every tick/done must match the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_tick_q.size() > 0 && exp_tick_q[0] < cyc) begin
        tests_run++; tests_failed++;
        e_tick = exp_tick_q.pop_front();
        $display("FAIL tick_missed: no tick seen, required at cycle %0d", e_tick);
      end
      if (exp_done_q.size() > 0 && exp_done_q[0] < cyc) begin
        tests_run++; tests_failed++;
        e_done = exp_done_q.pop_front();
        $display("FAIL done_missed: no done seen, required at cycle %0d", e_done);
      end
      if (tick) begin
        tests_run++;
        if (exp_tick_q.size() == 0) begin
          tests_failed++;
          $display("FAIL tick_unexpected: tick at cycle %0d, none required", cyc);
        end else begin
          e_tick = exp_tick_q.pop_front();
          if (cyc !== e_tick) begin
            tests_failed++;
            $display("FAIL tick_time: tick at cycle %0d, required %0d", cyc, e_tick);
          end
        end
      end
      if (done) begin
        tests_run++;
        if (exp_done_q.size() == 0) begin
          tests_failed++;
          $display("FAIL done_unexpected: done at cycle %0d, none required", cyc);
        end else begin
          e_done = exp_done_q.pop_front();
          if (cyc !== e_done) begin
            tests_failed++;
            $display("FAIL done_time: done at cycle %0d, required %0d", cyc, e_done);
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_run(input logic os, output int c0);
    start = 1'b1; oneshot = os;
    @(negedge clk);
    start = 1'b0; oneshot = 1'b0;
    c0 = cyc;
  endtask

  task automatic load_idle(input logic [CNT_W-1:0] p);
    load = 1'b1; period_in = p;
    @(negedge clk);
    load = 1'b0; period_in = '0;
  endtask

  task automatic stop_to_idle();
    stop = 1'b1;
    cycles(2);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (count !== 30'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if ({tick, wave, done} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_outs: tick/wave/done got %b want 000", {tick, wave, done});
    end
  endtask

  task automatic test_periodic();
    int c0;
    start_run(1'b0, c0);
    exp_tick_q.push_back(c0 + 5);
    exp_tick_q.push_back(c0 + 10);
    exp_tick_q.push_back(c0 + 15);
    wait_until(c0 + 2);
    tests_run++;
    if (count !== 30'd2) begin tests_failed++; $display("FAIL per_count: got %0d want 2", count); end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL per_busy: got %b want 1", busy); end
    for (int k = 1; k <= 3; k++) begin
      wait_until(c0 + 5 * k);
      tests_run++;
      if (wave !== k[0]) begin tests_failed++; $display("FAIL per_wave%0d: got %b want %b", k, wave, k[0]); end
    end
    stop_to_idle();
    tests_run++;
    if ({busy, wave, count} !== {1'b0, 1'b0, 30'd0}) begin
      tests_failed++; $display("FAIL per_stop: busy %b wave %b count %0d, want 0 0 0", busy, wave, count);
    end
  endtask

  task automatic test_oneshot();
    int c0;
    load = 1'b1; period_in = 30'd3; start = 1'b1; oneshot = 1'b1;
    @(negedge clk);
    load = 1'b0; period_in = '0; start = 1'b0; oneshot = 1'b0;
    c0 = cyc;
    exp_tick_q.push_back(c0 + 3);
    exp_done_q.push_back(c0 + 3);
    wait_until(c0 + 3);
    tests_run++;
    if ({done, busy, wave} !== 3'b101) begin
      tests_failed++; $display("FAIL os_end: done/busy/wave got %b want 101", {done, busy, wave});
    end
    cycles(8);
    tests_run++;
    if ({done, busy, count} !== {1'b0, 1'b0, 30'd0}) begin
      tests_failed++; $display("FAIL os_idle: done %b busy %b count %0d, want 0 0 0", done, busy, count);
    end
  endtask

  task automatic test_pause();
    int c0;
    int cr;
    load_idle(30'd8);
    start_run(1'b0, c0);
    wait_until(c0 + 4);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      tests_run++;
      if (count !== 30'd4) begin tests_failed++; $display("FAIL pause_frozen%0d: got %0d want 4", i, count); end
    end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL pause_busy: got %b want 1", busy); end
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cr = cyc;
    exp_tick_q.push_back(cr + 4);
    exp_tick_q.push_back(cr + 12);
    wait_until(cr + 4);
    tests_run++;
    if (wave !== 1'b0) begin tests_failed++; $display("FAIL resume_wave: got %b want 0", wave); end
    wait_until(cr + 14);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    tests_run++;
    if ({count, busy, wave} !== {30'd2, 1'b1, 1'b1}) begin
      tests_failed++; $display("FAIL pause2: count %0d busy %b wave %b, want 2 1 1", count, busy, wave);
    end
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    tests_run++;
    if ({count, busy, wave} !== {30'd0, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL pause_to_idle: count %0d busy %b wave %b, want 0 0 0", count, busy, wave);
    end
  endtask

  task automatic test_load_zero();
    int c0;
    load_idle(30'd0);
    start_run(1'b0, c0);
    exp_tick_q.push_back(c0 + 8);
    wait_until(c0 + 8);
    tests_run++;
    if (wave !== 1'b1) begin tests_failed++; $display("FAIL load0_wave: got %b want 1", wave); end
    stop_to_idle();
  endtask

  task automatic test_load_run();
    int c0;
`ifdef TIMEBASE_SHADOW_LOAD_EN
    load_idle(30'd10);
    start_run(1'b0, c0);
    exp_tick_q.push_back(c0 + 10);
    exp_tick_q.push_back(c0 + 14);
    exp_tick_q.push_back(c0 + 18);
    wait_until(c0 + 2);
    load_idle(30'd4);
    wait_until(c0 + 18);
    tests_run++;
    if (wave !== 1'b1) begin tests_failed++; $display("FAIL shadow_wave: got %b want 1", wave); end
`else
    start_run(1'b0, c0);
    exp_tick_q.push_back(c0 + 8);
    exp_tick_q.push_back(c0 + 16);
    wait_until(c0 + 10);
    load_idle(30'd6);
    wait_until(c0 + 16);
    tests_run++;
    if (wave !== 1'b0) begin tests_failed++; $display("FAIL runload_wave: got %b want 0", wave); end
`endif
    stop_to_idle();
  endtask

  task automatic test_p1();
    int c0;
    load_idle(30'd1);
    start_run(1'b0, c0);
    for (int k = 1; k <= 5; k++) exp_tick_q.push_back(c0 + k);
    for (int k = 1; k <= 4; k++) begin
      wait_until(c0 + k);
      tests_run++;
      if (wave !== k[0]) begin tests_failed++; $display("FAIL p1_wave%0d: got %b want %b", k, wave, k[0]); end
    end
    stop = 1'b1;
    cycles(1);
    tests_run++;
    if ({wave, busy, count} !== {1'b1, 1'b1, 30'd0}) begin
      tests_failed++; $display("FAIL tc_stop: wave %b busy %b count %0d, want 1 1 0", wave, busy, count);
    end
    cycles(1);
    stop = 1'b0;
    tests_run++;
    if ({wave, busy} !== 2'b00) begin tests_failed++; $display("FAIL p1_idle: wave/busy got %b want 00", {wave, busy}); end
  endtask

  task automatic test_reset_midrun();
    int c0;
    load_idle(30'd10);
    start_run(1'b0, c0);
    wait_until(c0 + 7);
    tests_run++;
    if (count !== 30'd7) begin tests_failed++; $display("FAIL mid_count: got %0d want 7", count); end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({count, tick, wave, done, busy} !== {30'd0, 4'b0000}) begin
      tests_failed++; $display("FAIL mid_reset: count %0d tick/wave/done/busy %b, want 0 0000", count, {tick, wave, done, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    cycles(1);
    start_run(1'b0, c0);
    exp_tick_q.push_back(c0 + 5);
    wait_until(c0 + 5);
    tests_run++;
    if (wave !== 1'b1) begin tests_failed++; $display("FAIL mid_defper_wave: got %b want 1", wave); end
    stop_to_idle();
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1;
    cycles(1);
    start = 1'b0; stop = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL ss_busy: got %b want 0", busy); end
    cycles(6);
    tests_run++;
    if ({busy, count} !== {1'b0, 30'd0}) begin
      tests_failed++; $display("FAIL ss_idle: busy %b count %0d, want 0 0", busy, count);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0; load = 1'b0; period_in = '0;
    cycles(3);
    test_reset();
    rst = 1'b0;
    cycles(1);
    test_periodic();
    test_oneshot();
    test_pause();
    test_load_zero();
    test_load_run();
    test_p1();
    test_reset_midrun();
    test_start_stop_idle();
    cycles(3);
    tests_run++;
    if (exp_tick_q.size() != 0 || exp_done_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drain: %0d tick / %0d done left, want 0 / 0", exp_tick_q.size(), exp_done_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
